axi4lite_sram_slave: RTL and testbench
======================================

Name: axi4lite_sram_slave

Overview:
- AXI4-Lite responder with internal word-addressed SRAM; the slave end of one LSU AXI4-Lite master port of the NPU.
- Instantiated once per LSU port in the NPU testbench and subsystem integration, as the memory behind `wa/wd/wr/ra/rd`.
- Write and read paths are independent, each with its own buffering and handshake control.
- Read latency is programmable to emulate slow memory.

Parameters:
- AXI_A_W, 32, address width (bytes).
- AXI_D_W, 32, data width; must be 32 or 64.
- AXI_S_W, AXI_D_W/8, strobe width.
- DEPTH, 1024, memory depth in words; power of two.
- RD_LAT, 2, extra read wait cycles, 0..15.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_i  in  1  asynchronous reset, active-high.
- wa_valid_i  in  1  write address valid.
- wa_ready_o  out  1  write address ready.
- wa_addr_i  in  AXI_A_W  write byte address.
- wd_valid_i  in  1  write data valid.
- wd_ready_o  out  1  write data ready.
- wd_data_i  in  AXI_D_W  write data.
- wd_strb_i  in  AXI_S_W  byte strobes.
- wr_valid_o  out  1  write response valid.
- wr_ready_i  in  1  write response ready.
- ra_valid_i  in  1  read address valid.
- ra_ready_o  out  1  read address ready.
- ra_addr_i  in  AXI_A_W  read byte address.
- rd_valid_o  out  1  read data valid.
- rd_ready_i  in  1  read data ready.
- rd_data_o  out  AXI_D_W  read data.

Behaviour:
- Reset (async, arst_i=1): wr_valid_o=0, rd_valid_o=0, rd_data_o=0, wa_ready_o=1, wd_ready_o=1, ra_ready_o=1.
  - Address/data buffers cleared; read FSM to R_IDLE; counter=0.
  - Memory array is not reset; contents are retained across reset, undefined at power-up.
- Word index: addr[log2(AXI_S_W)+log2(DEPTH)-1 : log2(AXI_S_W)]. Low byte-offset bits ignored.
- Out of range: any upper address bit set (address >= DEPTH*AXI_S_W).
  - Write is handshaken normally but memory is unchanged.
  - Read returns all zeros.
- Write path:
  - One-entry address buffer (aw_full) and one-entry data buffer (w_full).
  - wa_ready_o = ~aw_full; wd_ready_o = ~w_full. Address and data are accepted in any order, including the same cycle.
  - Commit condition: aw_full & w_full & (~wr_valid_o | wr_ready_i).
  - Commit updates memory bytes where strobe=1, clears both buffers, and sets wr_valid_o=1 next cycle.
  - wr_valid_o holds until wr_ready_i is sampled high, then clears unless a new commit occurs in the same cycle.
  - Sustained throughput: one write per 2 cycles.
  - Strobe all-zero: handshake completes, memory unchanged.
- Read FSM:
  - R_IDLE: ra_ready_o=1. On ra handshake, latch the index; go to R_WAIT with cnt=RD_LAT, or directly to R_RESP if RD_LAT=0.
  - R_WAIT: ra_ready_o=0; decrement cnt; at cnt=1 go to R_RESP.
  - Entering R_RESP: rd_data_o is loaded from memory, so rd_valid_o rises exactly RD_LAT+1 cycles after the ra handshake cycle.
  - R_RESP: rd_valid_o=1; rd_data_o stable while rd_ready_i=0. On handshake, go to R_IDLE, with rd_valid_o=0 next cycle.
- Read/write collision: memory is sampled on the R_RESP entry cycle. A write committing to the same word in that same cycle is not visible (read-before-write); a write committing any earlier cycle is visible.
- Reset mid-transaction: pending write or read is discarded with no response; the master must reissue it.
- Every valid output, once high, stays high with stable payload until its handshake; ready outputs never depend combinationally on inputs.

Test Plan:
- Write 0xDEADBEEF to 0x10 (strb 0xF), then read 0x10 with RD_LAT=2 -> wr_valid_o one cycle after commit; rd_valid_o 3 cycles after ra handshake; rd_data_o=0xDEADBEEF.
- Data before address: wd 0x11223344 at cycle 0, wa 0x20 at cycle 3; then strb 0x2 write of 0x0000AA00 to 0x20 -> each handshakes independently; read 0x20 returns 0x1122AA44.
- Backpressure: hold wr_ready_i=0 and rd_ready_i=0 for 5 cycles -> valids and rd_data_o stable; wa_ready_o/wd_ready_o drop after the next buffered beat; no second commit until the response is taken.
- Out of range: write 0x55 to address DEPTH*4, then read address DEPTH*4 -> both handshake; rd_data_o=0; word 0 unchanged.
- Collision: write 0xA5A5A5A5 to 0x40 committing on the R_RESP entry cycle of a read of 0x40 that previously held 0x1 -> rd_data_o=0x1; a following read returns 0xA5A5A5A5.
- Assert arst_i during R_WAIT with a buffered write address -> all valids 0 and readies 1 within the same cycle; memory word previously written still reads back correctly after reset.

Source files
------------

// File: rtl/axi4lite_sram_slave.sv
// AXI4-Lite slave backed by a word-addressed SRAM with byte strobes.
// Write and read channels run independently; read latency is programmable.
module axi4lite_sram_slave #(
   parameter int AXI_A_W = 32,
   parameter int AXI_D_W = 32,
   parameter int AXI_S_W = AXI_D_W / 8,
   parameter int DEPTH   = 1024,
   parameter int RD_LAT  = 2
) (
   input  logic               clk_i,
   input  logic               arst_i,
   input  logic               wa_valid_i,
   output logic               wa_ready_o,
   input  logic [AXI_A_W-1:0] wa_addr_i,
   input  logic               wd_valid_i,
   output logic               wd_ready_o,
   input  logic [AXI_D_W-1:0] wd_data_i,
   input  logic [AXI_S_W-1:0] wd_strb_i,
   output logic               wr_valid_o,
   input  logic               wr_ready_i,
   input  logic               ra_valid_i,
   output logic               ra_ready_o,
   input  logic [AXI_A_W-1:0] ra_addr_i,
   output logic               rd_valid_o,
   input  logic               rd_ready_i,
   output logic [AXI_D_W-1:0] rd_data_o
);
   localparam int OFF_W = $clog2(AXI_S_W);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

   typedef struct packed {
      logic             full;
      logic             oor;
      logic [IDX_W-1:0] idx;
   } aw_buf_t;

   typedef struct packed {
      logic               full;
      logic [AXI_S_W-1:0] strb;
      logic [AXI_D_W-1:0] data;
   } w_buf_t;

   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rd_state_t;

   logic [AXI_D_W-1:0] mem [DEPTH];

   aw_buf_t    aw_q;
   w_buf_t     w_q;
   rd_state_t  rd_state;
   logic [3:0] cnt;
   logic [IDX_W-1:0] rd_idx;
   logic       rd_oor;

   // Returns {out_of_range, word_index}; the whole address feeds the shift so
   // byte-offset bits are consumed even though they do not select anything.
   function automatic logic [IDX_W:0] decode(input logic [AXI_A_W-1:0] addr);
      logic [AXI_A_W-1:0] w;
      w = addr >> OFF_W;
      return {|(w >> IDX_W), w[IDX_W-1:0]};
   endfunction

   logic [IDX_W:0] wa_dec, ra_dec;
   logic           commit;

   assign wa_dec     = decode(wa_addr_i);
   assign ra_dec     = decode(ra_addr_i);
   assign wa_ready_o = ~aw_q.full;
   assign wd_ready_o = ~w_q.full;
   assign commit     = aw_q.full & w_q.full & (~wr_valid_o | wr_ready_i);

   // Write channel: single-entry address and data buffers, response register.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         aw_q       <= '0;
         w_q        <= '0;
         wr_valid_o <= 1'b0;
      end else begin
         if (commit) begin
            aw_q.full <= 1'b0;
            w_q.full  <= 1'b0;
         end else begin
            if (wa_valid_i && !aw_q.full) begin
               aw_q.full <= 1'b1;
               aw_q.oor  <= wa_dec[IDX_W];
               aw_q.idx  <= wa_dec[IDX_W-1:0];
            end
            if (wd_valid_i && !w_q.full) begin
               w_q.full <= 1'b1;
               w_q.strb <= wd_strb_i;
               w_q.data <= wd_data_i;
            end
         end
         if (commit)
            wr_valid_o <= 1'b1;
         else if (wr_ready_i)
            wr_valid_o <= 1'b0;
      end
   end

   // Storage is deliberately not reset so contents survive arst_i.
   always_ff @(posedge clk_i) begin
      if (commit && !aw_q.oor) begin
         for (int b = 0; b < AXI_S_W; b++)
            if (w_q.strb[b])
               mem[aw_q.idx][b*8 +: 8] <= w_q.data[b*8 +: 8];
      end
   end

   // Read channel. Data is sampled on the edge entering R_RESP, so a commit on
   // that same edge is not yet visible (read-before-write).
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         rd_state   <= R_IDLE;
         cnt        <= '0;
         rd_idx     <= '0;
         rd_oor     <= 1'b0;
         ra_ready_o <= 1'b1;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ra_valid_i) begin
                  rd_idx     <= ra_dec[IDX_W-1:0];
                  rd_oor     <= ra_dec[IDX_W];
                  ra_ready_o <= 1'b0;
                  if (RD_LAT == 0) begin
                     rd_state   <= R_RESP;
                     rd_valid_o <= 1'b1;
                     rd_data_o  <= ra_dec[IDX_W] ? '0 : mem[ra_dec[IDX_W-1:0]];
                  end else begin
                     rd_state <= R_WAIT;
                     cnt      <= RD_LAT_C;
                  end
               end
            end
            R_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rd_state   <= R_RESP;
                  rd_valid_o <= 1'b1;
                  rd_data_o  <= rd_oor ? '0 : mem[rd_idx];
               end
            end
            R_RESP: begin
               if (rd_ready_i) begin
                  rd_state   <= R_IDLE;
                  rd_valid_o <= 1'b0;
                  ra_ready_o <= 1'b1;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4lite_sram_slave.sv
// Directed bench for axi4lite_sram_slave (DEPTH=1024, RD_LAT=2, 32-bit data).
module tb_axi4lite_sram_slave;
   localparam int AW = 32, DW = 32, SW = 4, DEPTH = 1024, RD_LAT = 2;

   logic          clk_i = 1'b0, arst_i = 1'b1;
   logic          wa_valid_i = 0, wa_ready_o;
   logic [AW-1:0] wa_addr_i = '0;
   logic          wd_valid_i = 0, wd_ready_o;
   logic [DW-1:0] wd_data_i = '0;
   logic [SW-1:0] wd_strb_i = '0;
   logic          wr_valid_o, wr_ready_i = 0;
   logic          ra_valid_i = 0, ra_ready_o;
   logic [AW-1:0] ra_addr_i = '0;
   logic          rd_valid_o, rd_ready_i = 0;
   logic [DW-1:0] rd_data_o;

   int n_chk = 0, n_fail = 0;

   axi4lite_sram_slave #(.AXI_A_W(AW), .AXI_D_W(DW), .AXI_S_W(SW),
                         .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .wa_valid_i(wa_valid_i), .wa_ready_o(wa_ready_o), .wa_addr_i(wa_addr_i),
      .wd_valid_i(wd_valid_i), .wd_ready_o(wd_ready_o), .wd_data_i(wd_data_i),
      .wd_strb_i(wd_strb_i), .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
      .ra_valid_i(ra_valid_i), .ra_ready_o(ra_ready_o), .ra_addr_i(ra_addr_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
      logic aw_ok, w_ok, b_ok;
      aw_ok = 0; w_ok = 0; b_ok = 0;
      wa_valid_i = 1; wa_addr_i = a; wd_valid_i = 1; wd_data_i = d; wd_strb_i = s;
      wr_ready_i = 1;
      for (int i = 0; i < 20 && !b_ok; i++) begin
         if (wa_valid_i && wa_ready_o) aw_ok = 1;
         if (wd_valid_i && wd_ready_o) w_ok = 1;
         if (wr_valid_o && wr_ready_i) b_ok = 1;
         tick;
         if (aw_ok) wa_valid_i = 0;
         if (w_ok) wd_valid_i = 0;
      end
      wa_valid_i = 0; wd_valid_i = 0; wr_ready_i = 0;
      chk("wr_resp_seen", b_ok, 1);
   endtask

   task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
      logic a_ok, r_ok;
      a_ok = 0; r_ok = 0; d = 'x;
      ra_valid_i = 1; ra_addr_i = a; rd_ready_i = 1;
      for (int i = 0; i < 20 && !r_ok; i++) begin
         if (ra_valid_i && ra_ready_o) a_ok = 1;
         if (rd_valid_o && rd_ready_i) begin r_ok = 1; d = rd_data_o; end
         tick;
         if (a_ok) ra_valid_i = 0;
      end
      ra_valid_i = 0; rd_ready_i = 0;
      chk("rd_resp_seen", r_ok, 1);
   endtask

   logic [DW-1:0] rdat;

   initial begin
      // reset state
      tick; tick;
      chk("rst_wr_valid", wr_valid_o, 0);
      chk("rst_rd_valid", rd_valid_o, 0);
      chk("rst_rd_data", rd_data_o, 0);
      chk("rst_wa_ready", wa_ready_o, 1);
      chk("rst_wd_ready", wd_ready_o, 1);
      chk("rst_ra_ready", ra_ready_o, 1);
      arst_i = 0;
      tick;

      // basic write: both beats same cycle, commit next edge, response after
      wa_valid_i = 1; wa_addr_i = 32'h10; wd_valid_i = 1; wd_data_i = 32'hDEADBEEF; wd_strb_i = 4'hF;
      tick;
      wa_valid_i = 0; wd_valid_i = 0;
      chk("t1_wa_ready_full", wa_ready_o, 0);
      chk("t1_wd_ready_full", wd_ready_o, 0);
      chk("t1_wr_valid_pre", wr_valid_o, 0);
      tick;
      chk("t1_wr_valid", wr_valid_o, 1);
      chk("t1_wa_ready_free", wa_ready_o, 1);
      wr_ready_i = 1; tick; wr_ready_i = 0;
      chk("t1_wr_valid_clr", wr_valid_o, 0);

      // read with latency RD_LAT+1 = 3 cycles
      ra_valid_i = 1; ra_addr_i = 32'h10;
      chk("t1_ra_ready", ra_ready_o, 1);
      tick; ra_valid_i = 0;
      chk("t1_ra_ready_busy", ra_ready_o, 0);
      chk("t1_rd_valid_c1", rd_valid_o, 0);
      tick;
      chk("t1_rd_valid_c2", rd_valid_o, 0);
      tick;
      chk("t1_rd_valid_c3", rd_valid_o, 1);
      chk("t1_rd_data", rd_data_o, 32'hDEADBEEF);
      rd_ready_i = 1; tick; rd_ready_i = 0;
      chk("t1_rd_valid_clr", rd_valid_o, 0);
      chk("t1_ra_ready_back", ra_ready_o, 1);

      // data before address, then partial strobe
      wd_valid_i = 1; wd_data_i = 32'h11223344; wd_strb_i = 4'hF;
      tick; wd_valid_i = 0;
      chk("t2_wd_ready_full", wd_ready_o, 0);
      chk("t2_wa_ready_idle", wa_ready_o, 1);
      tick; tick;
      chk("t2_no_resp_yet", wr_valid_o, 0);
      wa_valid_i = 1; wa_addr_i = 32'h20;
      tick; wa_valid_i = 0;
      chk("t2_wr_valid_pre", wr_valid_o, 0);
      tick;
      chk("t2_wr_valid", wr_valid_o, 1);
      wr_ready_i = 1; tick; wr_ready_i = 0;
      do_write(32'h20, 32'h0000AA00, 4'b0010);
      do_read(32'h20, rdat);
      chk("t2_merge", rdat, 32'h1122AA44);

      // write backpressure: second write held in buffers until response taken
      wa_valid_i = 1; wa_addr_i = 32'h30; wd_valid_i = 1; wd_data_i = 32'h12345678; wd_strb_i = 4'hF;
      tick; wa_valid_i = 0; wd_valid_i = 0;
      tick;
      chk("t3_wr_valid", wr_valid_o, 1);
      wa_valid_i = 1; wa_addr_i = 32'h34; wd_valid_i = 1; wd_data_i = 32'h9;
      tick; wa_valid_i = 0; wd_valid_i = 0;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_wr_valid", wr_valid_o, 1);
         chk("t3_hold_wa_ready", wa_ready_o, 0);
         chk("t3_hold_wd_ready", wd_ready_o, 0);
         tick;
      end
      wr_ready_i = 1; tick;
      chk("t3_second_resp", wr_valid_o, 1);
      chk("t3_wa_ready_free", wa_ready_o, 1);
      tick; wr_ready_i = 0;
      chk("t3_resp_done", wr_valid_o, 0);
      do_read(32'h34, rdat);
      chk("t3_rd_second", rdat, 32'h9);

      // read backpressure: valid and data stable while rd_ready_i low
      ra_valid_i = 1; ra_addr_i = 32'h30;
      tick; ra_valid_i = 0;
      for (int i = 0; i < 10 && !rd_valid_o; i++) tick;
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_rd_valid", rd_valid_o, 1);
         chk("t3_hold_rd_data", rd_data_o, 32'h12345678);
         chk("t3_hold_ra_ready", ra_ready_o, 0);
         tick;
      end
      rd_ready_i = 1; tick; rd_ready_i = 0;
      chk("t3_rd_valid_clr", rd_valid_o, 0);

      // out of range: aliases word 0 in the low bits, must not touch it
      do_write(32'h0, 32'hCAFEF00D, 4'hF);
      do_write(DEPTH * 4, 32'h55, 4'hF);
      do_read(DEPTH * 4, rdat);
      chk("t4_oor_rd", rdat, 32'h0);
      do_read(32'h0, rdat);
      chk("t4_word0", rdat, 32'hCAFEF00D);

      // zero strobe: handshake, no change
      do_write(32'h0, 32'hFFFFFFFF, 4'h0);
      do_read(32'h0, rdat);
      chk("t4_zero_strb", rdat, 32'hCAFEF00D);

      // collision: commit on the R_RESP entry edge is not visible
      do_write(32'h40, 32'h1, 4'hF);
      ra_valid_i = 1; ra_addr_i = 32'h40;
      tick; ra_valid_i = 0;
      wa_valid_i = 1; wa_addr_i = 32'h40; wd_valid_i = 1; wd_data_i = 32'hA5A5A5A5; wd_strb_i = 4'hF;
      tick; wa_valid_i = 0; wd_valid_i = 0;
      tick;
      chk("t5_rd_valid", rd_valid_o, 1);
      chk("t5_wr_valid", wr_valid_o, 1);
      chk("t5_old_data", rd_data_o, 32'h1);
      rd_ready_i = 1; wr_ready_i = 1; tick; rd_ready_i = 0; wr_ready_i = 0;
      do_read(32'h40, rdat);
      chk("t5_new_data", rdat, 32'hA5A5A5A5);

      // reset during R_WAIT with a buffered write address
      do_write(32'h50, 32'h600DF00D, 4'hF);
      ra_valid_i = 1; ra_addr_i = 32'h50;
      tick; ra_valid_i = 0;
      wa_valid_i = 1; wa_addr_i = 32'h60;
      tick; wa_valid_i = 0;
      chk("t6_wa_buffered", wa_ready_o, 0);
      chk("t6_ra_busy", ra_ready_o, 0);
      arst_i = 1; #1;
      chk("t6_wr_valid", wr_valid_o, 0);
      chk("t6_rd_valid", rd_valid_o, 0);
      chk("t6_rd_data", rd_data_o, 0);
      chk("t6_wa_ready", wa_ready_o, 1);
      chk("t6_wd_ready", wd_ready_o, 1);
      chk("t6_ra_ready", ra_ready_o, 1);
      tick; arst_i = 0; tick;
      do_read(32'h50, rdat);
      chk("t6_retained", rdat, 32'h600DF00D);
      do_read(32'h10, rdat);
      chk("t6_retained_10", rdat, 32'hDEADBEEF);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
